// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU serial frame controller: instruction codes, FSM encoding, default widths.
// Pure package; no logic, no latency.
package pmu_pkg;

  localparam logic [3:0] PC_TO_SCAN = 4'd0;
  localparam logic [3:0] PC_TO_MEM  = 4'd1;
  localparam logic [3:0] MEM_TO_AES = 4'd2;
  localparam logic [3:0] PC_TO_KEY  = 4'd3;

  localparam int DEF_AES_DATA_WIDTH = 128;
  localparam int DEF_KEY_DATA_WIDTH = 128;
  localparam int DEF_MEM_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

  // Index of the final payload bit for a decoded instruction (payload length minus one).
  function automatic logic [7:0] last_idx(input logic [3:0] instr, input int aes_w,
                                          input int mem_w, input int key_w);
    case (instr)
      PC_TO_MEM: last_idx = 8'(mem_w - 1);
      PC_TO_KEY: last_idx = 8'(key_w - 1);
      default:   last_idx = 8'(aes_w - 1);
    endcase
  endfunction

endpackage

// File: rtl/pmu_frame_ctrl_if.sv
// Host-side serial link plus SIPO-side control outputs of the frame controller.
// master = host/bench side, slave = controller side.
interface pmu_frame_ctrl_if;
  logic       sdi;
  logic       sdi_valid;
  logic       en;
  logic [3:0] instruction;
  logic       data_o;
  logic       send;
  logic       busy;
  logic       err;

  modport master (output sdi, sdi_valid,
                  input  en, instruction, data_o, send, busy, err);
  modport slave  (input  sdi, sdi_valid,
                  output en, instruction, data_o, send, busy, err);
endinterface

// File: rtl/pmu_timeout_cnt.sv
// Counts consecutive idle (sdi_valid=0) cycles while a frame is open; o_expire is combinational
// and fires on the CYCLES-th idle cycle so the FSM can leave on that same edge. No backpressure.
module pmu_timeout_cnt
  import pmu_pkg::*;
#(
  parameter int CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_vld,
  output logic o_expire
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_run && !i_vld) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expire = i_run && !i_vld && (r_cnt == W'(CYCLES - 1));

endmodule

// File: rtl/pmu_frame_ctrl.sv
// Serial frame decoder: start bit, 4-bit LSB-first instruction, N payload bits forwarded to the SIPO
// with one cycle of latency; no backpressure, sdi_valid gaps stall. Idle timeout under PMU_FRAME_TIMEOUT_EN.
module pmu_frame_ctrl
  import pmu_pkg::*;
#(
  parameter int AES_DATA_WIDTH = DEF_AES_DATA_WIDTH,
  parameter int KEY_DATA_WIDTH = DEF_KEY_DATA_WIDTH,
  parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst,
  pmu_frame_ctrl_if.slave   bus
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_hdr, w_hdr_nxt;
  logic [3:0] r_instruction, w_instr_nxt;
  logic       r_en, r_data_o, r_send, r_busy, r_err;
  logic       w_en_nxt, w_data_nxt, w_send_nxt, w_busy_nxt, w_err_nxt;
  logic [3:0] w_hdr_val;
  logic [7:0] w_last;
  logic       w_timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef PMU_FRAME_TIMEOUT_EN
  logic w_run;
  assign w_run = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);

  pmu_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_vld    (bus.sdi_valid),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Header shifts in from the top, so after three bits r_hdr already holds {b2,b1,b0}.
  assign w_hdr_val = {bus.sdi, r_hdr};
  assign w_last    = last_idx(r_instruction, AES_DATA_WIDTH, MEM_DATA_WIDTH, KEY_DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hdr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hdr   <= w_hdr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_nxt   = r_hdr;
    case (r_state)
      ST_IDLE: begin
        if (bus.sdi_valid && bus.sdi) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = '0;
        end
      end
      ST_HDR: begin
        if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else if (bus.sdi_valid) begin
          if (r_cnt == 8'd3) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (w_hdr_val <= PC_TO_KEY) ? ST_PAYLOAD : ST_ERR;
          end else begin
            w_hdr_nxt = {bus.sdi, r_hdr[2:1]};
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else if (bus.sdi_valid) begin
          if (r_cnt == w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the next cycle; busy reflects the current state one cycle late.
  always_comb begin
    w_en_nxt    = 1'b0;
    w_send_nxt  = 1'b0;
    w_data_nxt  = r_data_o;
    w_instr_nxt = r_instruction;
    w_busy_nxt  = (r_state != ST_IDLE);
    w_err_nxt   = (w_state_nxt == ST_ERR);
    if (r_state == ST_PAYLOAD && bus.sdi_valid) begin
      w_en_nxt   = 1'b1;
      w_data_nxt = bus.sdi;
      w_send_nxt = (r_cnt == w_last);
    end
    if (r_state == ST_HDR && bus.sdi_valid && r_cnt == 8'd3) begin
      w_instr_nxt = w_hdr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en          <= 1'b0;
      r_data_o      <= 1'b0;
      r_send        <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_instruction <= '0;
    end else begin
      r_en          <= w_en_nxt;
      r_data_o      <= w_data_nxt;
      r_send        <= w_send_nxt;
      r_busy        <= w_busy_nxt;
      r_err         <= w_err_nxt;
      r_instruction <= w_instr_nxt;
    end
  end

  assign bus.en          = r_en;
  assign bus.data_o      = r_data_o;
  assign bus.send        = r_send;
  assign bus.busy        = r_busy;
  assign bus.err         = r_err;
  assign bus.instruction = r_instruction;

endmodule

// File: tb/tb_pmu_frame_ctrl.sv
// Directed bench for pmu_frame_ctrl: payload bits are queued as they are driven and
// popped by a negedge monitor whenever en is seen. Timeout branch follows PMU_FRAME_TIMEOUT_EN.
module tb_pmu_frame_ctrl;

  typedef struct packed {
    logic d;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   en_count;
  int   send_count;
  int   err_count;
  exp_t exp_q[$];

  pmu_frame_ctrl_if bus();

  pmu_frame_ctrl #(
    .AES_DATA_WIDTH (128),
    .KEY_DATA_WIDTH (128),
    .MEM_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every en must match the oldest queued payload bit.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.en) begin
        en_count++;
        chk("en_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_o", 32'(bus.data_o), 32'(e.d));
          chk("send_on_last", 32'(bus.send), 32'(e.last));
        end
      end else begin
        chk("send_without_en", 32'(bus.send), 32'd0);
      end
      if (bus.err)  err_count++;
      if (bus.send) send_count++;
    end
  end

  function automatic int plen(input logic [3:0] h);
    case (h)
      4'd1:    plen = 32;
      4'd3:    plen = 128;
      default: plen = 128;
    endcase
  endfunction

  task automatic drive_bit(input logic b);
    bus.sdi_valid = 1'b1;
    bus.sdi       = b;
    @(posedge clk); #1;
    bus.sdi_valid = 1'b0;
    bus.sdi       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic send_header(input logic [3:0] h);
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(h[i]);
  endtask

  task automatic send_payload(input int n, input int total, input int mode, input int first);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (mode == 1) ? logic'((first + i) % 2) : logic'($urandom_range(0, 1));
      exp_q.push_back('{d: b, last: (first + i == total - 1)});
      drive_bit(b);
    end
  endtask

  task automatic end_frame(input string tag, input logic [3:0] h, input int s0, input int e0,
                           input int n);
    sample();
    chk({tag, "_busy_at_send"}, 32'(bus.busy), 32'd1);
    chk({tag, "_instruction"}, 32'(bus.instruction), 32'(h));
    chk({tag, "_send_count"}, send_count, s0 + 1);
    chk({tag, "_en_count"}, en_count, e0 + n);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
    sample();
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    realign();
  endtask

  task automatic do_frame(input string tag, input logic [3:0] h, input int mode);
    int s0, e0;
    s0 = send_count;
    e0 = en_count;
    send_header(h);
    send_payload(plen(h), plen(h), mode, 0);
    end_frame(tag, h, s0, e0, plen(h));
  endtask

  initial begin
    int s0, e0, r0;
    n_checks = 0; n_fail = 0; en_count = 0; send_count = 0; err_count = 0;
    rst = 1'b1;
    bus.sdi = 1'b0;
    bus.sdi_valid = 1'b0;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_en", 32'(bus.en), 0);
    chk("rst_send", 32'(bus.send), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_data_o", 32'(bus.data_o), 0);
    chk("rst_instruction", 32'(bus.instruction), 0);
    realign();
    rst = 1'b0;

    // Valid zeros in IDLE are not start bits.
    repeat (3) drive_bit(1'b0);
    idle(1);
    sample();
    chk("idle_zero_busy", 32'(bus.busy), 0);
    realign();

    do_frame("key_frame", 4'd3, 0);
    do_frame("mem_frame", 4'd1, 1);

    // Bad header 9; instruction must hold the old value until the header completes.
    r0 = err_count; e0 = en_count; s0 = send_count;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    sample();
    chk("instruction_hold", 32'(bus.instruction), 32'd1);
    realign();
    drive_bit(1'b1);
    idle(4);
    sample();
    chk("bad_hdr_err_pulses", err_count, r0 + 1);
    chk("bad_hdr_no_en", en_count, e0);
    chk("bad_hdr_no_send", send_count, s0);
    chk("bad_hdr_busy", 32'(bus.busy), 0);
    realign();
    do_frame("aes_after_err", 4'd2, 0);

    // Reset after 50 payload bits of a 128-bit frame.
    s0 = send_count;
    send_header(4'd0);
    send_payload(50, 128, 0, 0);
    sample();
    rst = 1'b1;
    realign();
    sample();
    chk("midrst_en", 32'(bus.en), 0);
    chk("midrst_send", 32'(bus.send), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_err", 32'(bus.err), 0);
    chk("midrst_data_o", 32'(bus.data_o), 0);
    chk("midrst_instruction", 32'(bus.instruction), 0);
    realign();
    rst = 1'b0;
    chk("midrst_no_send", send_count, s0);
    chk("midrst_queue", exp_q.size(), 0);
    do_frame("after_rst", 4'd3, 0);

    // Sixteen idle cycles in the middle of a 32-bit payload.
    r0 = err_count; e0 = en_count; s0 = send_count;
    send_header(4'd1);
    send_payload(20, 32, 0, 0);
    idle(16);
`ifdef PMU_FRAME_TIMEOUT_EN
    idle(4);
    sample();
    chk("timeout_err_pulses", err_count, r0 + 1);
    chk("timeout_no_send", send_count, s0);
    chk("timeout_busy", 32'(bus.busy), 0);
    chk("timeout_queue", exp_q.size(), 0);
    realign();
    do_frame("after_timeout", 4'd1, 1);
`else
    sample();
    chk("stall_no_err", err_count, r0);
    chk("stall_busy", 32'(bus.busy), 1);
    chk("stall_no_send", send_count, s0);
    realign();
    send_payload(12, 32, 0, 20);
    end_frame("stall_resume", 4'd1, s0, e0, 32);
`endif

    idle(3);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmu_frame_ctrl.md
PMU_FRAME_CTRL -- requirements
Module: pmu_frame_ctrl

Interface
REQ-001 Parameter AES_DATA_WIDTH, default 128, payload bit count for instructions 0 and 2.
REQ-002 Parameter KEY_DATA_WIDTH, default 128, payload bit count for instruction 3.
REQ-003 Parameter MEM_DATA_WIDTH, default 32, payload bit count for instruction 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, maximum idle cycles between frame bits.
REQ-005 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port sdi, input, 1 bit: serial data from the host.
REQ-008 Port sdi_valid, input, 1 bit: sdi is sampled only in cycles where this is high.
REQ-009 Port en, output, 1 bit: shift-enable to the SIPO stage.
REQ-010 Port instruction, output, 4 bits: decoded frame instruction to the SIPO stage.
REQ-011 Port data_o, output, 1 bit: serial payload bit to the SIPO stage.
REQ-012 Port send, output, 1 bit: one-cycle word-complete strobe to the SIPO stage.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 Port err, output, 1 bit: one-cycle pulse on a bad instruction or a timeout.

Function
REQ-015 States: IDLE, HDR, PAYLOAD, ERR; all outputs are registered.
REQ-016 IDLE: a cycle with sdi_valid=1 and sdi=1 is the start bit; go to HDR with the bit counter cleared. sdi=0 bits are ignored.
REQ-017 HDR: capture 4 valid bits LSB-first into instruction; after the 4th bit, go to PAYLOAD if the value is 0..3, else go to ERR.
REQ-018 PAYLOAD length: N = AES_DATA_WIDTH for instructions 0 and 2, MEM_DATA_WIDTH for 1, KEY_DATA_WIDTH for 3.
REQ-019 PAYLOAD: each valid bit drives en=1 and data_o=sdi in the next cycle; en=0 in every other cycle.
REQ-020 The N-th payload bit asserts send=1 in the same cycle as its en=1; the FSM then returns to IDLE.
REQ-021 ERR: err=1 for exactly one cycle, then IDLE; en and send stay 0.
REQ-022 instruction holds its value after the frame ends until the next HDR completes.
REQ-023 The bit counter is 8 bits wide, counts valid bits only, and never wraps within a frame.
REQ-024 sdi_valid gaps inside a frame stall the FSM without losing state.

Reset
REQ-025 While rst=1 on a clock edge: state=IDLE, counters=0, en=0, send=0, err=0, busy=0, data_o=0, instruction=0.
REQ-026 rst mid-frame discards the partial frame; send is never issued for it.

Configuration
REQ-027 With PMU_FRAME_TIMEOUT_EN defined: in HDR or PAYLOAD, TIMEOUT_CYCLES consecutive cycles with sdi_valid=0 force ERR (err pulse, then IDLE, no send).
REQ-028 Without PMU_FRAME_TIMEOUT_EN: no timeout counter exists, and a frame waits indefinitely.

Structure
REQ-029 Package pmu_pkg holds the instruction codes (PC_TO_SCAN=0, PC_TO_MEM=1, MEM_TO_AES=2, PC_TO_KEY=3), the state encoding, and the default widths.
REQ-030 The timeout counter is sub-module pmu_timeout_cnt, instantiated only under PMU_FRAME_TIMEOUT_EN.

Verification
REQ-031 Start bit, header 0011 LSB-first (value 3), 128 payload bits -> 128 en pulses; send coincides with the 128th; instruction=3; busy falls the next cycle.
REQ-032 Header value 1, 32 alternating payload bits -> data_o follows sdi one cycle late; exactly 32 en pulses; send on the 32nd.
REQ-033 Header value 9 -> single err pulse, no en, return to IDLE; a following valid frame completes normally.
REQ-034 Reset asserted after 50 payload bits -> outputs at reset values next cycle; no send; a new frame completes normally.
REQ-035 With PMU_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16, sdi_valid held low for 16 cycles mid-payload -> err pulse, no send; without the macro the same stimulus stalls, and the frame completes once bits resume.
